stream_rr_arbiter: RTL and testbench

- Two-requester AXI-stream arbiter that shares the counter datapath's single slave stream input between two upstream producers.
- Ownership is granted per packet, using round-robin priority.
- Ownership is released on a tlast beat or when a programmable beat limit is reached.
- Exposes grant status and a packet-done pulse for the PS-side controller.

---
 rtl/stream_rr_arbiter.sv | 98 +++++++++
 tb/tb_stream_rr_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Two-requester AXI-stream arbiter with per-packet round-robin ownership.
// A grant ends on tlast or after MAX_BEATS beats, whichever comes first.
module stream_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset_n,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic                  s0_valid,
    input  logic                  s0_last,
    output logic                  s0_ready,
    input  logic [DATA_WIDTH-1:0] s1_data,
    input  logic                  s1_valid,
    input  logic                  s1_last,
    output logic                  s1_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    input  logic                  i_hold,
    output logic [1:0]            o_grant,
    output logic                  o_pkt_done,
    output logic                  o_forced
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_BEATS - 1);

    state_t                state;
    logic                  owner;
    logic                  rr_ptr;
    logic [CNT_WIDTH-1:0]  beat_cnt;

    logic [DATA_WIDTH-1:0] own_data;
    logic                  own_valid;
    logic                  own_last;
    logic                  busy;
    logic                  beat;
    logic                  pick;

    // Passthrough is gated by state, so readies and m_valid drop as soon as reset asserts.
    always_comb begin
        own_data  = owner ? s1_data  : s0_data;
        own_valid = owner ? s1_valid : s0_valid;
        own_last  = owner ? s1_last  : s0_last;
        busy      = (state == BUSY);
        m_data    = own_data;
        m_valid   = busy & own_valid;
        m_last    = busy & (own_last | (beat_cnt == LAST_CNT));
        s0_ready  = busy & ~owner & m_ready;
        s1_ready  = busy &  owner & m_ready;
        beat      = m_valid & m_ready;
        pick      = (s0_valid & s1_valid) ? rr_ptr : s1_valid;
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            rr_ptr     <= 1'b0;
            beat_cnt   <= '0;
            o_grant    <= 2'b00;
            o_pkt_done <= 1'b0;
            o_forced   <= 1'b0;
        end else begin
            o_pkt_done <= 1'b0;
            o_forced   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!i_hold && (s0_valid || s1_valid)) begin
                        owner   <= pick;
                        o_grant <= pick ? 2'b10 : 2'b01;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (beat) begin
                        if (m_last) begin
                            state      <= IDLE;
                            beat_cnt   <= '0;
                            o_grant    <= 2'b00;
                            o_pkt_done <= 1'b1;
                            o_forced   <= ~own_last;
                            rr_ptr     <= ~owner;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: one instance at the default beat limit,
// a second at MAX_BEATS=4 sharing the same inputs for forced-release checks.
module tb_stream_rr_arbiter;

    logic        axi_clk;
    logic        axi_reset_n;
    logic [31:0] s0_data, s1_data;
    logic        s0_valid, s0_last, s1_valid, s1_last;
    logic        m_ready, i_hold;

    logic        s0_ready, s1_ready, m_valid, m_last, o_pkt_done, o_forced;
    logic [31:0] m_data;
    logic [1:0]  o_grant;

    logic        s0_ready4, s1_ready4, m_valid4, m_last4, o_pkt_done4, o_forced4;
    logic [31:0] m_data4;
    logic [1:0]  o_grant4;

    int n_cmp = 0;
    int n_err = 0;

    stream_rr_arbiter #(.DATA_WIDTH(32), .MAX_BEATS(256), .CNT_WIDTH(16)) dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .i_hold(i_hold), .o_grant(o_grant), .o_pkt_done(o_pkt_done), .o_forced(o_forced)
    );

    stream_rr_arbiter #(.DATA_WIDTH(32), .MAX_BEATS(4), .CNT_WIDTH(16)) dut4 (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready4),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready4),
        .m_data(m_data4), .m_valid(m_valid4), .m_last(m_last4), .m_ready(m_ready),
        .i_hold(i_hold), .o_grant(o_grant4), .o_pkt_done(o_pkt_done4), .o_forced(o_forced4)
    );

    initial begin
        axi_clk = 1'b0;
        forever #5 axi_clk = ~axi_clk;
    end

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic do_reset();
        axi_reset_n = 1'b0;
        tick();
        tick();
        axi_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        s0_valid = 1'b1; s1_valid = 1'b1; s0_last = 1'b0; s1_last = 1'b0;
        s0_data = 32'hAAAA_0000; s1_data = 32'hBBBB_0000; m_ready = 1'b1; i_hold = 1'b0;
        axi_reset_n = 1'b0;
        tick();
        n_cmp++; if (o_grant !== 2'b00) begin n_err++; $display("FAIL rst_grant got=%b exp=00", o_grant); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
        n_cmp++; if ({s0_ready, s1_ready} !== 2'b00) begin n_err++; $display("FAIL rst_readies got=%b exp=00", {s0_ready, s1_ready}); end
        n_cmp++; if ({o_pkt_done, o_forced} !== 2'b00) begin n_err++; $display("FAIL rst_pulses got=%b exp=00", {o_pkt_done, o_forced}); end
        s0_valid = 1'b0; s1_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_single_packet();
        s0_valid = 1'b1; s0_last = 1'b0; s0_data = 32'hC0DE_0000; m_ready = 1'b1;
        #1;
        n_cmp++; if ({o_grant, s0_ready, m_valid} !== 4'b0000) begin n_err++; $display("FAIL t1_idle got=%b exp=0000", {o_grant, s0_ready, m_valid}); end
        tick();
        for (int i = 0; i < 4; i++) begin
            s0_data = 32'hC0DE_0000 + i; s0_last = (i == 3);
            #1;
            n_cmp++; if (o_grant !== 2'b01) begin n_err++; $display("FAIL t1_grant beat=%0d got=%b exp=01", i, o_grant); end
            n_cmp++; if (m_valid !== 1'b1 || m_data !== 32'hC0DE_0000 + i) begin n_err++; $display("FAIL t1_data beat=%0d got=%h/%b exp=%h/1", i, m_data, m_valid, 32'hC0DE_0000 + i); end
            n_cmp++; if (m_last !== (i == 3)) begin n_err++; $display("FAIL t1_last beat=%0d got=%b exp=%b", i, m_last, (i == 3)); end
            n_cmp++; if ({s0_ready, s1_ready} !== 2'b10) begin n_err++; $display("FAIL t1_ready beat=%0d got=%b exp=10", i, {s0_ready, s1_ready}); end
            tick();
        end
        s0_valid = 1'b0; s0_last = 1'b0;
        #1;
        n_cmp++; if ({o_pkt_done, o_forced, o_grant} !== 4'b1000) begin n_err++; $display("FAIL t1_done got=%b exp=1000", {o_pkt_done, o_forced, o_grant}); end
        tick();
        n_cmp++; if (o_pkt_done !== 1'b0) begin n_err++; $display("FAIL t1_done_pulse got=%b exp=0", o_pkt_done); end
    endtask

    task automatic test_round_robin();
        int k0, k1, own, kk;
        logic [31:0] exp_d;
        s0_valid = 1'b1; s1_valid = 1'b1; m_ready = 1'b1; i_hold = 1'b0;
        s0_data = 32'h1000_0000; s1_data = 32'h2000_0000; s0_last = 1'b0; s1_last = 1'b0;
        do_reset();
        k0 = 0; k1 = 0;
        for (int c = 0; c < 16; c++) begin
            own = (c / 4) % 2;
            s0_data = 32'h1000_0000 + k0; s0_last = (k0 % 3 == 2);
            s1_data = 32'h2000_0000 + k1; s1_last = (k1 % 3 == 2);
            #1;
            if (c % 4 == 0) begin
                n_cmp++; if ({o_grant, s0_ready, s1_ready, m_valid} !== 5'b00000) begin n_err++; $display("FAIL t2_idle c=%0d got=%b exp=00000", c, {o_grant, s0_ready, s1_ready, m_valid}); end
                if (c > 0) begin
                    n_cmp++; if (o_pkt_done !== 1'b1) begin n_err++; $display("FAIL t2_done c=%0d got=%b exp=1", c, o_pkt_done); end
                end
            end else begin
                kk    = own ? k1 : k0;
                exp_d = (own ? 32'h2000_0000 : 32'h1000_0000) + kk;
                n_cmp++; if (o_grant !== (own ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL t2_grant c=%0d got=%b exp=%b", c, o_grant, (own ? 2'b10 : 2'b01)); end
                n_cmp++; if ({s0_ready, s1_ready} !== (own ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL t2_ready c=%0d got=%b exp=%b", c, {s0_ready, s1_ready}, (own ? 2'b01 : 2'b10)); end
                n_cmp++; if (m_data !== exp_d || m_last !== (kk % 3 == 2)) begin n_err++; $display("FAIL t2_data c=%0d got=%h/%b exp=%h/%b", c, m_data, m_last, exp_d, (kk % 3 == 2)); end
                if (own == 1) k1++; else k0++;
            end
            tick();
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
    endtask

    task automatic test_forced_release();
        int k;
        logic idle;
        s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1; i_hold = 1'b0;
        do_reset();
        k = 0;
        for (int c = 0; c < 14; c++) begin
            s1_valid = (k < 10); s1_data = 32'h5000_0000 + k; s1_last = (k == 9);
            idle = (c == 0 || c == 5 || c == 10 || c == 13);
            #1;
            if (idle) begin
                n_cmp++; if ({o_grant4, m_valid4} !== 3'b000) begin n_err++; $display("FAIL t3_idle c=%0d got=%b exp=000", c, {o_grant4, m_valid4}); end
                if (c > 0) begin
                    n_cmp++; if ({o_pkt_done4, o_forced4} !== {1'b1, (c != 13)}) begin n_err++; $display("FAIL t3_done c=%0d got=%b exp=%b", c, {o_pkt_done4, o_forced4}, {1'b1, (c != 13)}); end
                end
            end else begin
                n_cmp++; if (o_grant4 !== 2'b10 || {s0_ready4, s1_ready4} !== 2'b01) begin n_err++; $display("FAIL t3_grant c=%0d got=%b/%b exp=10/01", c, o_grant4, {s0_ready4, s1_ready4}); end
                n_cmp++; if (m_data4 !== 32'h5000_0000 + k) begin n_err++; $display("FAIL t3_data c=%0d got=%h exp=%h", c, m_data4, 32'h5000_0000 + k); end
                n_cmp++; if (m_last4 !== (k == 3 || k == 7 || k == 9)) begin n_err++; $display("FAIL t3_last c=%0d got=%b exp=%b", c, m_last4, (k == 3 || k == 7 || k == 9)); end
                k++;
            end
            tick();
        end
        s1_valid = 1'b0; s1_last = 1'b0;
    endtask

    task automatic test_backpressure();
        int k;
        s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1; i_hold = 1'b0;
        do_reset();
        k = 0;
        for (int c = 0; c < 10; c++) begin
            s0_valid = (k < 4); s0_data = 32'h7000_0000 + k; s0_last = (k == 3);
            m_ready  = (c == 0) ? 1'b1 : 1'((c - 1) % 2);
            #1;
            if (c >= 1 && c <= 8) begin
                n_cmp++; if (o_grant !== 2'b01 || o_grant4 !== 2'b01) begin n_err++; $display("FAIL t4_grant c=%0d got=%b/%b exp=01/01", c, o_grant, o_grant4); end
                n_cmp++; if (m_valid !== 1'b1 || m_data !== 32'h7000_0000 + k) begin n_err++; $display("FAIL t4_data c=%0d got=%h/%b exp=%h/1", c, m_data, m_valid, 32'h7000_0000 + k); end
                n_cmp++; if ({m_last, m_last4} !== {2{k == 3}}) begin n_err++; $display("FAIL t4_last c=%0d got=%b exp=%b", c, {m_last, m_last4}, {2{k == 3}}); end
                n_cmp++; if (s0_ready !== m_ready) begin n_err++; $display("FAIL t4_ready c=%0d got=%b exp=%b", c, s0_ready, m_ready); end
                if (m_ready) k++;
            end else if (c == 9) begin
                n_cmp++; if ({o_pkt_done, o_forced, o_pkt_done4, o_forced4} !== 4'b1010) begin n_err++; $display("FAIL t4_done got=%b exp=1010", {o_pkt_done, o_forced, o_pkt_done4, o_forced4}); end
            end
            tick();
        end
        s0_valid = 1'b0; s0_last = 1'b0; m_ready = 1'b1;
    endtask

    task automatic test_hold();
        s0_valid = 1'b1; s1_valid = 1'b1; s0_last = 1'b1; s1_last = 1'b0;
        s0_data = 32'h9000_0001; m_ready = 1'b1; i_hold = 1'b1;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++; if ({o_grant, s0_ready, s1_ready, m_valid} !== 5'b00000) begin n_err++; $display("FAIL t5_hold c=%0d got=%b exp=00000", c, {o_grant, s0_ready, s1_ready, m_valid}); end
            tick();
        end
        i_hold = 1'b0;
        #1;
        n_cmp++; if (o_grant !== 2'b00) begin n_err++; $display("FAIL t5_release_same got=%b exp=00", o_grant); end
        tick();
        n_cmp++; if (o_grant !== 2'b01) begin n_err++; $display("FAIL t5_release_grant got=%b exp=01", o_grant); end
        i_hold = 1'b1;
        #1;
        n_cmp++; if ({m_valid, m_last, s0_ready} !== 3'b111) begin n_err++; $display("FAIL t5_busy_hold got=%b exp=111", {m_valid, m_last, s0_ready}); end
        tick();
        n_cmp++; if ({o_pkt_done, o_forced, o_grant} !== 4'b1000) begin n_err++; $display("FAIL t5_done got=%b exp=1000", {o_pkt_done, o_forced, o_grant}); end
        tick();
        n_cmp++; if (o_grant !== 2'b00) begin n_err++; $display("FAIL t5_rehold got=%b exp=00", o_grant); end
    endtask

    task automatic test_reset_mid_packet();
        s1_valid = 1'b0; s0_valid = 1'b1; s0_last = 1'b0; s0_data = 32'hD000_0000; i_hold = 1'b0;
        tick();
        #1;
        n_cmp++; if (o_grant !== 2'b01 || m_valid !== 1'b1) begin n_err++; $display("FAIL t6_beat1 got=%b/%b exp=01/1", o_grant, m_valid); end
        tick();
        s0_data = 32'hD000_0001;
        axi_reset_n = 1'b0;
        #1;
        n_cmp++; if ({m_valid, s0_ready, s1_ready, o_grant} !== 5'b00000) begin n_err++; $display("FAIL t6_async got=%b exp=00000", {m_valid, s0_ready, s1_ready, o_grant}); end
        s1_valid = 1'b1;
        tick();
        axi_reset_n = 1'b1;
        #1;
        n_cmp++; if (o_grant !== 2'b00) begin n_err++; $display("FAIL t6_after_rst got=%b exp=00", o_grant); end
        tick();
        n_cmp++; if (o_grant !== 2'b01 || s1_ready !== 1'b0) begin n_err++; $display("FAIL t6_rr_reset got=%b/%b exp=01/0", o_grant, s1_ready); end
        s0_valid = 1'b0; s1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_forced_release();
        test_backpressure();
        test_hold();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
